// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch resolution, EX/MEM register.
// Define M_EXT_EN to build in the iterative multiply/divide unit and its stall logic.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_EX_PC,
  input  logic [31:0] ID_EX_DAT1,
  input  logic [31:0] ID_EX_DAT2,
  input  logic [31:0] ID_EX_imm,
  input  logic [4:0]  ID_EX_rd_reg1,
  input  logic [4:0]  ID_EX_rd_reg2,
  input  logic [4:0]  ID_EX_wr_reg,
  input  logic [2:0]  ID_EX_funct3,
  input  logic [6:0]  ID_EX_funct7,
  input  logic        ID_EX_regwrite,
  input  logic        ID_EX_alusrc,
  input  logic        ID_EX_memread,
  input  logic        ID_EX_memwrite,
  input  logic        ID_EX_memtoreg,
  input  logic        ID_EX_branch,
  input  logic [1:0]  ID_EX_aluop,
  input  logic [4:0]  MEM_WB_wr_reg,
  input  logic        MEM_WB_regwrite,
  input  logic [31:0] MEM_WB_wr_data,
  input  logic        EX_MEM_flush,
  output logic        ex_stall,
  output logic [31:0] EX_MEM_alu_result,
  output logic [31:0] EX_MEM_DAT2,
  output logic [31:0] EX_MEM_branch_target,
  output logic [4:0]  EX_MEM_wr_reg,
  output logic        EX_MEM_taken,
  output logic        EX_MEM_regwrite,
  output logic        EX_MEM_memread,
  output logic        EX_MEM_memwrite,
  output logic        EX_MEM_memtoreg,
  output logic        EX_MEM_branch
);

  logic [31:0] fwd_a, fwd_b, op_b, alu_res, br_tgt;
  logic [4:0]  shamt;
  logic        alt, cond, is_m_fn;
  logic        m_done;
  logic [31:0] m_res, m_dat2;

  always_comb begin
    if (EX_MEM_regwrite && EX_MEM_wr_reg == ID_EX_rd_reg1 && ID_EX_rd_reg1 != 5'd0)
      fwd_a = EX_MEM_alu_result;
    else if (MEM_WB_regwrite && MEM_WB_wr_reg == ID_EX_rd_reg1 && ID_EX_rd_reg1 != 5'd0)
      fwd_a = MEM_WB_wr_data;
    else
      fwd_a = ID_EX_DAT1;
    if (EX_MEM_regwrite && EX_MEM_wr_reg == ID_EX_rd_reg2 && ID_EX_rd_reg2 != 5'd0)
      fwd_b = EX_MEM_alu_result;
    else if (MEM_WB_regwrite && MEM_WB_wr_reg == ID_EX_rd_reg2 && ID_EX_rd_reg2 != 5'd0)
      fwd_b = MEM_WB_wr_data;
    else
      fwd_b = ID_EX_DAT2;
  end

  assign op_b    = ID_EX_alusrc ? ID_EX_imm : fwd_b;
  assign br_tgt  = ID_EX_PC + ID_EX_imm;
  assign is_m_fn = (ID_EX_aluop == 2'b10) && (ID_EX_funct7 == 7'b0000001);

  // I-type only honours funct7[5] for SRAI; ADDI never subtracts
  always_comb begin
    alt     = ID_EX_funct7[5] && (ID_EX_aluop == 2'b10 || ID_EX_funct3 == 3'b101);
    shamt   = op_b[4:0];
    alu_res = '0;
    case (ID_EX_aluop)
      2'b00: alu_res = fwd_a + op_b;
      2'b01: alu_res = fwd_a - op_b;
      default: begin
        if (!is_m_fn) begin
          case (ID_EX_funct3)
            3'b000:  alu_res = alt ? fwd_a - op_b : fwd_a + op_b;
            3'b001:  alu_res = fwd_a << shamt;
            3'b010:  alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
            3'b011:  alu_res = {31'd0, fwd_a < op_b};
            3'b100:  alu_res = fwd_a ^ op_b;
            3'b101:  alu_res = alt ? $unsigned($signed(fwd_a) >>> shamt) : fwd_a >> shamt;
            3'b110:  alu_res = fwd_a | op_b;
            default: alu_res = fwd_a & op_b;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    case (ID_EX_funct3)
      3'b000:  cond = (fwd_a == fwd_b);
      3'b001:  cond = (fwd_a != fwd_b);
      3'b100:  cond = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  cond = (fwd_a < fwd_b);
      3'b111:  cond = (fwd_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

`ifdef M_EXT_EN
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [63:0] acc, acc_step, prod;
  logic [31:0] mag_b, raw_a, raw_b, mag_a_c, quo, rem;
  logic [32:0] mul_sum, div_trial, div_diff;
  logic [2:0]  m_f3;
  logic        neg_q, neg_r, b_zero, a_neg, b_neg, m_op;

  assign m_op     = is_m_fn && ID_EX_regwrite;
  assign ex_stall = (state == IDLE && m_op) || state == BUSY;
  assign m_done   = (state == DONE);
  assign m_dat2   = raw_b;

  // Signed ops: MUL/MULH/MULHSU/DIV/REM on rs1; MUL/MULH/DIV/REM on rs2
  assign a_neg   = fwd_a[31] && (ID_EX_funct3[2] ? !ID_EX_funct3[0] : ID_EX_funct3[1:0] != 2'b11);
  assign b_neg   = fwd_b[31] && (ID_EX_funct3[2] ? !ID_EX_funct3[0] : !ID_EX_funct3[1]);
  assign mag_a_c = a_neg ? 32'd0 - fwd_a : fwd_a;

  // acc = {hi, multiplier} for multiply, {remainder, quotient} for divide
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
  assign div_trial = acc[63:31];
  assign div_diff  = div_trial - {1'b0, mag_b};
  assign acc_step  = m_f3[2] ? (div_diff[32] ? {div_trial[31:0], acc[30:0], 1'b0}
                                             : {div_diff[31:0], acc[30:0], 1'b1})
                             : {mul_sum, acc[31:1]};

  always_comb begin
    prod = neg_q ? 64'd0 - acc : acc;
    quo  = neg_q ? 32'd0 - acc[31:0] : acc[31:0];
    rem  = neg_r ? 32'd0 - acc[63:32] : acc[63:32];
    case (m_f3)
      3'b000:         m_res = prod[31:0];
      3'b100, 3'b101: m_res = b_zero ? '1 : quo;
      3'b110, 3'b111: m_res = b_zero ? raw_a : rem;
      default:        m_res = prod[63:32];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mag_b  <= '0;
      raw_a  <= '0;
      raw_b  <= '0;
      m_f3   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else if (EX_MEM_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (m_op) begin
          acc    <= {32'd0, mag_a_c};
          mag_b  <= b_neg ? 32'd0 - fwd_b : fwd_b;
          raw_a  <= fwd_a;
          raw_b  <= fwd_b;
          m_f3   <= ID_EX_funct3;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          b_zero <= (fwd_b == 32'd0);
          count  <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          acc   <= acc_step;
          count <= count + 5'd1;
          if (count == 5'd31) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign ex_stall = 1'b0;
  assign m_done   = 1'b0;
  assign m_res    = '0;
  assign m_dat2   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_MEM_alu_result    <= '0;
      EX_MEM_DAT2          <= '0;
      EX_MEM_branch_target <= '0;
      EX_MEM_wr_reg        <= '0;
      EX_MEM_taken         <= 1'b0;
      EX_MEM_regwrite      <= 1'b0;
      EX_MEM_memread       <= 1'b0;
      EX_MEM_memwrite      <= 1'b0;
      EX_MEM_memtoreg      <= 1'b0;
      EX_MEM_branch        <= 1'b0;
    end else if (EX_MEM_flush || ex_stall) begin
      EX_MEM_taken    <= 1'b0;
      EX_MEM_regwrite <= 1'b0;
      EX_MEM_memread  <= 1'b0;
      EX_MEM_memwrite <= 1'b0;
      EX_MEM_memtoreg <= 1'b0;
      EX_MEM_branch   <= 1'b0;
    end else begin
      EX_MEM_alu_result    <= m_done ? m_res : alu_res;
      EX_MEM_DAT2          <= m_done ? m_dat2 : fwd_b;
      EX_MEM_branch_target <= br_tgt;
      EX_MEM_wr_reg        <= ID_EX_wr_reg;
      EX_MEM_taken         <= !m_done && ID_EX_branch && cond;
      EX_MEM_regwrite      <= ID_EX_regwrite;
      EX_MEM_memread       <= ID_EX_memread;
      EX_MEM_memwrite      <= ID_EX_memwrite;
      EX_MEM_memtoreg      <= ID_EX_memtoreg;
      EX_MEM_branch        <= ID_EX_branch;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a reference model predicts every EX/MEM update; a monitor compares.
// M_EXT_EN-specific sequences are included when that macro is defined.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ID_EX_PC, ID_EX_DAT1, ID_EX_DAT2, ID_EX_imm;
  logic [4:0]  ID_EX_rd_reg1, ID_EX_rd_reg2, ID_EX_wr_reg;
  logic [2:0]  ID_EX_funct3;
  logic [6:0]  ID_EX_funct7;
  logic        ID_EX_regwrite, ID_EX_alusrc, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg, ID_EX_branch;
  logic [1:0]  ID_EX_aluop;
  logic [4:0]  MEM_WB_wr_reg;
  logic        MEM_WB_regwrite;
  logic [31:0] MEM_WB_wr_data;
  logic        EX_MEM_flush;
  logic        ex_stall;
  logic [31:0] EX_MEM_alu_result, EX_MEM_DAT2, EX_MEM_branch_target;
  logic [4:0]  EX_MEM_wr_reg;
  logic        EX_MEM_taken, EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memwrite, EX_MEM_memtoreg, EX_MEM_branch;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .ID_EX_PC(ID_EX_PC), .ID_EX_DAT1(ID_EX_DAT1), .ID_EX_DAT2(ID_EX_DAT2), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rd_reg1(ID_EX_rd_reg1), .ID_EX_rd_reg2(ID_EX_rd_reg2), .ID_EX_wr_reg(ID_EX_wr_reg),
    .ID_EX_funct3(ID_EX_funct3), .ID_EX_funct7(ID_EX_funct7),
    .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_alusrc(ID_EX_alusrc), .ID_EX_memread(ID_EX_memread),
    .ID_EX_memwrite(ID_EX_memwrite), .ID_EX_memtoreg(ID_EX_memtoreg), .ID_EX_branch(ID_EX_branch),
    .ID_EX_aluop(ID_EX_aluop),
    .MEM_WB_wr_reg(MEM_WB_wr_reg), .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_wr_data(MEM_WB_wr_data),
    .EX_MEM_flush(EX_MEM_flush), .ex_stall(ex_stall),
    .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_DAT2(EX_MEM_DAT2),
    .EX_MEM_branch_target(EX_MEM_branch_target), .EX_MEM_wr_reg(EX_MEM_wr_reg),
    .EX_MEM_taken(EX_MEM_taken), .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memread(EX_MEM_memread),
    .EX_MEM_memwrite(EX_MEM_memwrite), .EX_MEM_memtoreg(EX_MEM_memtoreg), .EX_MEM_branch(EX_MEM_branch)
  );

  typedef struct packed {
    logic [31:0] res, dat2, tgt;
    logic [4:0]  rd;
    logic        rw, mr, mw, mtr, br, tk;
  } exm_t;

  typedef struct {
    int   due;
    exm_t v;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc, d1, d2, imm, wbdat;
    logic [4:0]  rs1, rs2, rd, wbreg;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  aluop;
    logic        alusrc, rw, mr, mw, mtr, br, wbrw, flush;
  } instr_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exm_t mdl;
  exp_t e;
  exm_t got;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exm_t dut_out();
    return {EX_MEM_alu_result, EX_MEM_DAT2, EX_MEM_branch_target, EX_MEM_wr_reg, EX_MEM_regwrite,
            EX_MEM_memread, EX_MEM_memwrite, EX_MEM_memtoreg, EX_MEM_branch, EX_MEM_taken};
  endfunction

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      got = dut_out();
      total++;
      if (e.due != cyc || got !== e.v) begin
        bad++;
        $display("FAIL exmem cyc=%0d due=%0d got res=%h dat2=%h tgt=%h rd=%0d ctl=%b%b%b%b%b%b want res=%h dat2=%h tgt=%h rd=%0d ctl=%b%b%b%b%b%b",
                 cyc, e.due, got.res, got.dat2, got.tgt, got.rd, got.rw, got.mr, got.mw, got.mtr, got.br, got.tk,
                 e.v.res, e.v.dat2, e.v.tgt, e.v.rd, e.v.rw, e.v.mr, e.v.mw, e.v.mtr, e.v.br, e.v.tk);
      end
    end
  end

  function automatic exm_t bubble(input exm_t p);
    exm_t q = p;
    q.rw = 1'b0; q.mr = 1'b0; q.mw = 1'b0; q.mtr = 1'b0; q.br = 1'b0; q.tk = 1'b0;
    return q;
  endfunction

  // value the instruction sees for register rs, given what EX/MEM and MEM/WB currently hold
  function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] rf, input instr_t t);
    if (rs == 5'd0) return rf;
    if (mdl.rw && mdl.rd == rs) return mdl.res;
    if (t.wbrw && t.wbreg == rs) return t.wbdat;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input instr_t t, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic sub_sra;
    sa = a; sb = b;
    sub_sra = t.f7[5] && (t.aluop == 2'b10 || t.f3 == 3'd5);
    if (t.aluop == 2'b00) return a + b;
    if (t.aluop == 2'b01) return a - b;
    if (t.aluop == 2'b10 && t.f7 == 7'd1) return 32'd0;
    case (t.f3)
      3'd0: return sub_sra ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return sub_sra ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y, p;
    int sa, sb;
    sa = a; sb = b;
    x = (f3 == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
    y = (f3 == 3'd2 || f3 == 3'd3) ? {32'd0, b} : {{32{b[31]}}, b};
    p = x * y;
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input instr_t t);
    ID_EX_PC = t.pc; ID_EX_DAT1 = t.d1; ID_EX_DAT2 = t.d2; ID_EX_imm = t.imm;
    ID_EX_rd_reg1 = t.rs1; ID_EX_rd_reg2 = t.rs2; ID_EX_wr_reg = t.rd;
    ID_EX_funct3 = t.f3; ID_EX_funct7 = t.f7; ID_EX_aluop = t.aluop;
    ID_EX_regwrite = t.rw; ID_EX_alusrc = t.alusrc; ID_EX_memread = t.mr;
    ID_EX_memwrite = t.mw; ID_EX_memtoreg = t.mtr; ID_EX_branch = t.br;
    MEM_WB_wr_reg = t.wbreg; MEM_WB_regwrite = t.wbrw; MEM_WB_wr_data = t.wbdat;
    EX_MEM_flush = t.flush;
  endtask

  task automatic push(input exm_t v);
    exp_t x;
    x.due = cyc + 1;
    x.v = v;
    sbq.push_back(x);
    mdl = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input instr_t t);
    logic [31:0] a, b;
    exm_t nxt;
    drive(t);
    #1;
    a = src_val(t.rs1, t.d1, t);
    b = src_val(t.rs2, t.d2, t);
    total++;
    if (ex_stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_idle cyc=%0d got=%b want=0", cyc, ex_stall);
    end
    if (t.flush) nxt = bubble(mdl);
    else nxt = {alu_ref(t, a, t.alusrc ? t.imm : b), b, t.pc + t.imm, t.rd,
                t.rw, t.mr, t.mw, t.mtr, t.br, t.br && br_ref(t.f3, a, b)};
    push(nxt);
    step();
  endtask

  function automatic instr_t mk(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                                input logic alusrc, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm);
    instr_t t = '0;
    t.aluop = aluop; t.f3 = f3; t.f7 = f7; t.alusrc = alusrc;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.d1 = d1; t.d2 = d2; t.imm = imm; t.rw = 1'b1;
    return t;
  endfunction

  function automatic instr_t rnd();
    instr_t t;
    logic [6:0] f7s [3];
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;
    t.pc = $urandom & 32'hFFFF_FFFC;
    t.d1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    t.d2 = ($urandom_range(0, 3) == 0) ? t.d1 : $urandom;
    t.imm = $urandom;
    t.wbdat = $urandom;
    t.rs1 = 5'($urandom_range(0, 3));
    t.rs2 = 5'($urandom_range(0, 3));
    t.rd = 5'($urandom_range(0, 3));
    t.wbreg = 5'($urandom_range(0, 3));
    t.f3 = 3'($urandom);
    t.aluop = 2'($urandom);
`ifdef M_EXT_EN
    t.f7 = f7s[$urandom_range(0, 1)];
`else
    t.f7 = f7s[$urandom_range(0, 2)];
`endif
    t.alusrc = 1'($urandom); t.rw = 1'($urandom); t.mr = 1'($urandom); t.mw = 1'($urandom);
    t.mtr = 1'($urandom); t.br = (t.aluop == 2'b01); t.wbrw = 1'($urandom);
    t.flush = ($urandom_range(0, 7) == 0);
    return t;
  endfunction

`ifdef M_EXT_EN
  task automatic issue_m(input instr_t t);
    logic [31:0] a, b, r;
    int n;
    drive(t);
    #1;
    a = src_val(t.rs1, t.d1, t);
    b = src_val(t.rs2, t.d2, t);
    r = m_ref(t.f3, a, b);
    n = 0;
    while (ex_stall === 1'b1 && n < 40) begin
      n++;
      push(bubble(mdl));
      step();
      MEM_WB_wr_data = $urandom;
      MEM_WB_wr_reg = 5'($urandom_range(0, 3));
      #1;
    end
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL stall_len f3=%0d got=%0d want=33", t.f3, n);
    end
    push({r, b, t.pc + t.imm, t.rd, t.rw, t.mr, t.mw, t.mtr, t.br, 1'b0});
    step();
  endtask

  task automatic issue_m_flush(input instr_t t, input int at_busy);
    drive(t);
    #1;
    push(bubble(mdl));
    step();
    for (int i = 1; i <= at_busy; i++) begin
      if (i == at_busy) begin
        EX_MEM_flush = 1'b1;
        #1;
        total++;
        if (ex_stall !== 1'b1) begin
          bad++;
          $display("FAIL stall_busy got=%b want=1", ex_stall);
        end
      end
      push(bubble(mdl));
      step();
    end
  endtask
`endif

  initial begin
    instr_t t;
    rst = 1'b1;
    drive('0);
    mdl = '0;
    @(negedge clk);
    total++;
    if (dut_out() !== '0 || ex_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset got=%h stall=%b want=0", dut_out(), ex_stall);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    issue(mk(2'b10, 3'd0, 7'h00, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0));
    issue(mk(2'b11, 3'd0, 7'h00, 1'b1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h10));
    t = mk(2'b10, 3'd0, 7'h00, 1'b0, 5'd1, 5'd0, 5'd4, 32'hDEAD, 32'd0, 32'd0);
    t.wbreg = 5'd1; t.wbrw = 1'b1; t.wbdat = 32'h20;
    issue(t);
    issue(mk(2'b11, 3'd0, 7'h00, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h10));
    t = mk(2'b10, 3'd0, 7'h00, 1'b0, 5'd0, 5'd0, 5'd5, 32'h55, 32'd1, 32'd0);
    t.wbreg = 5'd0; t.wbrw = 1'b1; t.wbdat = 32'h20;
    issue(t);
    t = mk(2'b01, 3'd4, 7'h00, 1'b0, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd8);
    t.rw = 1'b0; t.br = 1'b1; t.pc = 32'h100;
    issue(t);
    t.f3 = 3'd6;
    issue(t);
    issue(mk(2'b10, 3'd5, 7'h20, 1'b0, 5'd6, 5'd7, 5'd8, 32'h8000_0000, 32'd4, 32'd0));
    issue(mk(2'b11, 3'd5, 7'h20, 1'b1, 5'd6, 5'd7, 5'd9, 32'h8000_0000, 32'd0, 32'h404));
    issue(mk(2'b11, 3'd5, 7'h00, 1'b1, 5'd6, 5'd7, 5'd10, 32'h8000_0000, 32'd0, 32'h4));
    issue(mk(2'b11, 3'd0, 7'h20, 1'b1, 5'd6, 5'd7, 5'd11, 32'd9, 32'd0, 32'h3));
    issue(mk(2'b10, 3'd0, 7'h20, 1'b0, 5'd6, 5'd7, 5'd12, 32'd9, 32'd3, 32'd0));

    for (int i = 0; i < 300; i++) issue(rnd());

`ifdef M_EXT_EN
    issue_m(mk(2'b10, 3'd4, 7'h01, 1'b0, 5'd6, 5'd7, 5'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0));
    issue_m(mk(2'b10, 3'd5, 7'h01, 1'b0, 5'd6, 5'd7, 5'd2, 32'd7, 32'd0, 32'd0));
    issue_m(mk(2'b10, 3'd6, 7'h01, 1'b0, 5'd6, 5'd7, 5'd3, 32'd7, 32'd0, 32'd0));
    issue(mk(2'b10, 3'd0, 7'h00, 1'b0, 5'd3, 5'd2, 5'd4, 32'd0, 32'd0, 32'd0));
    for (int i = 0; i < 12; i++) begin
      t = rnd();
      t.aluop = 2'b10; t.f7 = 7'h01; t.rw = 1'b1; t.flush = 1'b0;
      if (i < 8) t.f3 = 3'(i);
      issue_m(t);
    end
    issue_m_flush(mk(2'b10, 3'd1, 7'h01, 1'b0, 5'd6, 5'd7, 5'd5, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0), 10);
    for (int i = 0; i < 10; i++) begin
      t = rnd();
      t.flush = 1'b0;
      issue(t);
    end
`endif

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
